// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the 800x600@72Hz VGA timing generator.
// Default raster geometry, coordinate/colour widths and the test-pattern bar decoder.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FP_DEF      = 56;
    localparam int unsigned H_SYNC_DEF    = 120;
    localparam int unsigned H_BP_DEF      = 64;
    localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_VISIBLE_DEF = 600;
    localparam int unsigned V_FP_DEF      = 37;
    localparam int unsigned V_SYNC_DEF    = 6;
    localparam int unsigned V_BP_DEF      = 23;
    localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned R_W     = 3;
    localparam int unsigned G_W     = 3;
    localparam int unsigned B_W     = 2;
    localparam int unsigned RGB_W   = R_W + G_W + B_W;

    // Eight 100-pixel bars; bar index bits select full-scale R, G and B.
    function automatic logic [RGB_W-1:0] bar_colour(input logic [9:0] x);
        logic [2:0] k;
        k = 3'(x / 10'd100);
        return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Bundle between the timing generator, the game logic and the VGA pins.
// TestPatternSel exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] PixelX;
    logic [COORD_W-1:0] PixelY;
    logic               VideoOn;
    logic               FrameStart;
    logic [R_W-1:0]     RIn;
    logic [G_W-1:0]     GIn;
    logic [B_W-1:0]     BIn;
    logic               HSync;
    logic               VSync;
    logic [R_W-1:0]     ROut;
    logic [G_W-1:0]     GOut;
    logic [B_W-1:0]     BOut;
`ifdef VGA_TEST_PATTERN_EN
    logic               TestPatternSel;
`endif

    modport master (
        output PixelX, PixelY, VideoOn, FrameStart, HSync, VSync, ROut, GOut, BOut,
        input  RIn, GIn, BIn
`ifdef VGA_TEST_PATTERN_EN
        , input TestPatternSel
`endif
    );

    modport slave (
        input  PixelX, PixelY, VideoOn, FrameStart, HSync, VSync, ROut, GOut, BOut,
        output RIn, GIn, BIn
`ifdef VGA_TEST_PATTERN_EN
        , output TestPatternSel
`endif
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear to ResetVal.
// Depth 0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned      Depth    = 1,
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_stages
        logic [Width-1:0] stage_q [Depth];
        logic [Width-1:0] stage_d [Depth];

        always_comb begin
            stage_d[0] = d_i;
            for (int i = 1; i < Depth; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int i = 0; i < Depth; i++) begin
                    stage_q[i] <= ResetVal;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, sync decode, colour realignment and blanking.
// Define VGA_TEST_PATTERN_EN to add the TestPatternSel colour-bar source.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic  uclk,
    input  logic  reset,
    vga_if.master bus
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DW = 3 + RGB_W;
`else
    localparam int unsigned DW = 3;
`endif
    // Delay stages reset to "blank, sync inactive" so reset never leaks a partial pulse.
    localparam logic [DW-1:0] DL_RESET = DW'({~SYNC_POL, ~SYNC_POL, 1'b0}) << (DW - 3);

    logic [COORD_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic hs_raw, vs_raw, vis_raw;
    logic [DW-1:0] dl_in, dl_out;
    logic hs_dl, vs_dl, vis_dl;
    logic [R_W-1:0] r_src, r_d, r_q;
    logic [G_W-1:0] g_src, g_d, g_q;
    logic [B_W-1:0] b_src, b_d, b_q;
    logic hsync_d, hsync_q, vsync_d, vsync_q;

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == COORD_W'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == COORD_W'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
        end
    end

    assign hs_raw  = (hcnt_q >= COORD_W'(HS_START) && hcnt_q < COORD_W'(HS_END)) ?
                     SYNC_POL : ~SYNC_POL;
    assign vs_raw  = (vcnt_q >= COORD_W'(VS_START) && vcnt_q < COORD_W'(VS_END)) ?
                     SYNC_POL : ~SYNC_POL;
    assign vis_raw = (hcnt_q < COORD_W'(H_VISIBLE)) && (vcnt_q < COORD_W'(V_VISIBLE));

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {hs_raw, vs_raw, vis_raw, bar_colour(hcnt_q[9:0])};
`else
    assign dl_in = {hs_raw, vs_raw, vis_raw};
`endif

    vga_delay_line #(
        .Depth    (PIPE_DELAY),
        .Width    (DW),
        .ResetVal (DL_RESET)
    ) u_delay (
        .clk_i  (uclk),
        .rst_ni (reset),
        .d_i    (dl_in),
        .q_o    (dl_out)
    );

    assign {hs_dl, vs_dl, vis_dl} = dl_out[DW-1 -: 3];

    always_comb begin
        {r_src, g_src, b_src} = {bus.RIn, bus.GIn, bus.BIn};
`ifdef VGA_TEST_PATTERN_EN
        if (bus.TestPatternSel) begin
            {r_src, g_src, b_src} = dl_out[RGB_W-1:0];
        end
`endif
        hsync_d = hs_dl;
        vsync_d = vs_dl;
        r_d     = vis_dl ? r_src : '0;
        g_d     = vis_dl ? g_src : '0;
        b_d     = vis_dl ? b_src : '0;
    end

    always_ff @(posedge uclk) begin
        if (!reset) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign bus.PixelX     = hcnt_q;
    assign bus.PixelY     = vcnt_q;
    assign bus.VideoOn    = vis_raw;
    assign bus.FrameStart = reset && (hcnt_q == '0) && (vcnt_q == '0);
    assign bus.HSync      = hsync_q;
    assign bus.VSync      = vsync_q;
    assign bus.ROut       = r_q;
    assign bus.GOut       = g_q;
    assign bus.BOut       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, shortened vertical timing to keep runs short.
// Frame model is pure arithmetic on the number of clocks since reset release.
module tb_vga_timing_gen;

    localparam int PD = 1;
    localparam int HV = 800, HF = 56, HS = 120, HB = 64;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 6, VF = 3, VS = 2, VB = 2;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // clocks seen with reset high since the last reset, plus per-clock sampled inputs
    int       k = 0;
    bit [7:0] rgb_hist [16];
    bit       sel_hist [16];

    vga_if bus ();

    vga_timing_gen #(
        .V_VISIBLE (VV),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .PIPE_DELAY(PD)
    ) dut (
        .uclk  (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (k=%0d)", name, act, exp, k);
        end
    endtask

    function automatic int x_of(input int i);
        return (i % FT) % HT;
    endfunction

    function automatic int y_of(input int i);
        return (i % FT) / HT;
    endfunction

    function automatic int vis_at(input int i);
        return (i >= 0 && x_of(i) < HV && y_of(i) < VV) ? 1 : 0;
    endfunction

    function automatic int hs_at(input int i);
        return (i >= 0 && x_of(i) >= HV + HF && x_of(i) < HV + HF + HS) ? 1 : 0;
    endfunction

    function automatic int vs_at(input int i);
        return (i >= 0 && y_of(i) >= VV + VF && y_of(i) < VV + VF + VS) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int nk;
        nk = rst_n ? k + 1 : 0;
        k <= nk;
        rgb_hist[nk % 16] <= {bus.RIn, bus.GIn, bus.BIn};
`ifdef VGA_TEST_PATTERN_EN
        sel_hist[nk % 16] <= bus.TestPatternSel;
`else
        sel_hist[nk % 16] <= 1'b0;
`endif
    end

    // Outputs at clock k reflect the raster position of clock k-PD-1 and the colour sampled at k.
    always @(negedge clk) begin
        int idx, bar, er, eg, eb;
        if (chk_en) begin
            idx = k - PD - 1;
            chk("PixelX", int'(bus.PixelX), x_of(k));
            chk("PixelY", int'(bus.PixelY), y_of(k));
            chk("VideoOn", int'(bus.VideoOn), vis_at(k));
            chk("FrameStart", int'(bus.FrameStart), (rst_n && (k % FT) == 0) ? 1 : 0);
            chk("HSync", int'(bus.HSync), hs_at(idx));
            chk("VSync", int'(bus.VSync), vs_at(idx));
            er = 0; eg = 0; eb = 0;
            if (vis_at(idx) == 1) begin
                if (sel_hist[k % 16]) begin
                    bar = x_of(idx) / 100;
                    er = (bar & 4) != 0 ? 7 : 0;
                    eg = (bar & 2) != 0 ? 7 : 0;
                    eb = (bar & 1) != 0 ? 3 : 0;
                end else begin
                    er = int'(rgb_hist[k % 16][7:5]);
                    eg = int'(rgb_hist[k % 16][4:2]);
                    eb = int'(rgb_hist[k % 16][1:0]);
                end
            end
            chk("ROut", int'(bus.ROut), er);
            chk("GOut", int'(bus.GOut), eg);
            chk("BOut", int'(bus.BOut), eb);
        end
    end

    initial begin
        int first_hs, hs_count, fs_prev, fs_gap, vs_run, vs_len, ymax, found;
        bus.RIn = 3'd7;
        bus.GIn = 3'd5;
        bus.BIn = 2'd2;
`ifdef VGA_TEST_PATTERN_EN
        bus.TestPatternSel = 1'b0;
`endif
        @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset held: pins idle, raster parked at origin
        repeat (10) begin
            @(negedge clk);
            chk("rst_hsync", int'(bus.HSync), 0);
            chk("rst_rout", int'(bus.ROut), 0);
            chk("rst_frame_start", int'(bus.FrameStart), 0);
            chk("rst_pixelx", int'(bus.PixelX), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // First line: counter start, HSync placement and width, right-edge blanking
        first_hs = -1;
        hs_count = 0;
        for (int n = 0; n < HT; n++) begin
            if (n < 10) chk("release_pixelx", int'(bus.PixelX), n);
            if (n == 801) chk("last_visible_rout", int'(bus.ROut), 7);
            if (n == 802) chk("x800_rout_blank", int'(bus.ROut), 0);
            if (bus.HSync && first_hs < 0) first_hs = n;
            if (bus.HSync) hs_count++;
            @(negedge clk);
        end
        chk("hsync_rise_clock", first_hs, 858);
        chk("hsync_width", hs_count, 120);

        // Two frames: FrameStart period, VSync width, row range, bottom blanking
        fs_prev = 0;
        fs_gap = -1;
        vs_run = 0;
        vs_len = -1;
        ymax = 0;
        for (int n = HT; n < 2 * FT + HT; n++) begin
            if (bus.FrameStart) begin
                if (fs_gap < 0) fs_gap = n - fs_prev;
                fs_prev = n;
            end
            if (bus.VSync) vs_run++;
            else begin
                if (vs_run > 0 && vs_len < 0) vs_len = vs_run;
                vs_run = 0;
            end
            if (int'(bus.PixelY) > ymax) ymax = int'(bus.PixelY);
            if (n == (VV - 1) * HT + 102) chk("last_row_rout", int'(bus.ROut), 7);
            if (n == VV * HT + 102) chk("row_blank_rout", int'(bus.ROut), 0);
            if (n > FT) begin
                bus.RIn = 3'($urandom_range(7));
                bus.GIn = 3'($urandom_range(7));
                bus.BIn = 2'($urandom_range(3));
            end
            @(negedge clk);
        end
        chk("frame_start_gap", fs_gap, FT);
        chk("vsync_width", vs_len, VS * HT);
        chk("pixely_max", ymax, VT - 1);

        // Reset in the middle of both sync pulses
        found = 0;
        for (int n = 0; n < 2 * FT && found == 0; n++) begin
            @(negedge clk);
            if (int'(bus.PixelX) == 899 && int'(bus.PixelY) == VV + VF) found = 1;
        end
        chk("midsync_reached", found, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_hsync", int'(bus.HSync), 1);
        chk("pre_reset_vsync", int'(bus.VSync), 1);
        @(negedge clk);
        chk("reset_hsync_off", int'(bus.HSync), 0);
        chk("reset_vsync_off", int'(bus.VSync), 0);
        chk("reset_pixelx", int'(bus.PixelX), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
        bus.TestPatternSel = 1'b1;
`endif
        @(negedge clk);
        chk("restart_pixelx", int'(bus.PixelX), 0);
        chk("restart_pixely", int'(bus.PixelY), 0);
        chk("restart_frame_start", int'(bus.FrameStart), 1);
        for (int n = 1; n < 800; n++) begin
            bus.RIn = 3'($urandom_range(7));
            @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
            if (n == 152) begin
                chk("bar_px150_r", int'(bus.ROut), 0);
                chk("bar_px150_g", int'(bus.GOut), 0);
                chk("bar_px150_b", int'(bus.BOut), 3);
            end
            if (n == 752) begin
                chk("bar_px750_r", int'(bus.ROut), 7);
                chk("bar_px750_g", int'(bus.GOut), 7);
                chk("bar_px750_b", int'(bus.BOut), 3);
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
